// File: rtl/serial_result_transmitter_pkg.sv
// Shared serial definitions: sync byte, byte-frame state encoding and frame sizing.
// SERIAL_TX_CHECKSUM_EN adds one trailing XOR checksum byte to each result frame.
package serial_result_transmitter_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } frame_state_e;

  function automatic int unsigned frame_bytes(input int unsigned nonce_bytes);
`ifdef SERIAL_TX_CHECKSUM_EN
    return nonce_bytes + 4;
`else
    return nonce_bytes + 3;
`endif
  endfunction

endpackage

// File: rtl/serial_result_transmitter_uart_tx_byte.sv
// One 8N1 byte on the UART line, LSB first. A load may land on the same edge that ends
// the stop bit (done_o high), which gives back-to-back bytes with no idle gap.
module serial_result_transmitter_uart_tx_byte
  import serial_result_transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  frame_state_e    r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_tx, w_tx_next;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == CntMax);
  assign done_o    = (r_state == StStop) && w_bit_end;
  assign tx_o      = r_tx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;

    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        w_tx_next  = 1'b1;
      end
      StStart: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_state_next = StData;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = StStop;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_state_next = StIdle;
          w_tx_next    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_tx_next    = 1'b1;
      end
    endcase

    // Load wins over everything: it either starts from idle or chains off the stop bit.
    if (load_i) begin
      w_state_next = StStart;
      w_cnt_next   = '0;
      w_bit_next   = '0;
      w_shift_next = data_i;
      w_tx_next    = 1'b0;
    end
  end

endmodule

// File: rtl/serial_result_transmitter.sv
// Result return path: captures one nonce + score and sends it as a byte frame over UART.
// Build option SERIAL_TX_CHECKSUM_EN appends an XOR checksum byte after nonce byte 0.
module serial_result_transmitter
  import serial_result_transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NONCE_BYTES  = 16,
  parameter int unsigned SCORE_WIDTH  = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  input  logic [NONCE_BYTES*8-1:0] nonce_i,
  input  logic [SCORE_WIDTH-1:0]   score_i,
  output logic                     busy_o,
  output logic                     tx_o
);

  localparam int unsigned FrameBytes = frame_bytes(NONCE_BYTES);
  localparam int unsigned IdxW       = $clog2(FrameBytes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameBytes - 1);

  logic [NONCE_BYTES*8-1:0] r_nonce;
  logic [15:0]              r_score;
  logic                     r_busy;
  logic                     r_pending;
  logic [IdxW-1:0]          r_idx;
  logic [IdxW-1:0]          w_sel;
  logic [7:0]               w_byte;
  logic                     w_accept;
  logic                     w_done;
  logic                     w_last;
  logic                     w_load;
`ifdef SERIAL_TX_CHECKSUM_EN
  logic [7:0]               r_csum;
`endif

  assign w_accept       = result_valid_i && !r_busy;
  assign w_last         = (r_idx == LastIdx);
  // r_pending marks the first byte of a frame; later bytes chain off the previous done.
  assign w_load         = r_pending || (w_done && !w_last);
  assign w_sel          = r_pending ? '0 : r_idx + 1'b1;
  assign result_ready_o = !r_busy;
  assign busy_o         = r_busy;

  always_comb begin
    w_byte = SYNC_BYTE;
    if (w_sel == IdxW'(1)) begin
      w_byte = r_score[15:8];
    end else if (w_sel == IdxW'(2)) begin
      w_byte = r_score[7:0];
    end
    for (int j = 0; j < int'(NONCE_BYTES); j++) begin
      if (w_sel == IdxW'(3 + j)) begin
        w_byte = r_nonce[(int'(NONCE_BYTES) - 1 - j)*8 +: 8];
      end
    end
`ifdef SERIAL_TX_CHECKSUM_EN
    if (w_sel == LastIdx) begin
      w_byte = r_csum;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nonce   <= '0;
      r_score   <= '0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
      r_idx     <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else if (w_accept) begin
      r_nonce   <= nonce_i;
      r_score   <= 16'(score_i);
      r_busy    <= 1'b1;
      r_pending <= 1'b1;
      r_idx     <= '0;
`ifdef SERIAL_TX_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      if (w_load) begin
        r_pending <= 1'b0;
        r_idx     <= w_sel;
`ifdef SERIAL_TX_CHECKSUM_EN
        r_csum    <= r_csum ^ w_byte;
`endif
      end
      if (w_done && w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  serial_result_transmitter_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(w_load),
    .data_i(w_byte),
    .done_o(w_done),
    .tx_o  (tx_o)
  );

endmodule
